// File: rtl/detect_timestamp.sv
// Timestamps single-cycle detect pulses against a free-running 32-bit timer and queues them in a 4-entry FWFT FIFO.
// Optional dead-time after each detect is compiled in with DETECT_TIMESTAMP_HOLDOFF_EN.
module detect_timestamp #(
  // Timer value during a ts_clear cycle; it counts up from CLEAR_VALUE + 1 on the next cycle.
  parameter logic [31:0] CLEAR_VALUE = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        detect,
  input  logic        ts_clear,
  input  logic        rd_en,
`ifdef DETECT_TIMESTAMP_HOLDOFF_EN
  input  logic [31:0] holdoff,
`endif
  output logic [31:0] ts_data,
  output logic        ts_valid,
  output logic [2:0]  ts_count,
  output logic        overflow
);

  // Read side: ts_valid acts as "valid" and rd_en as "ready"; an entry leaves
  // the FIFO only on a cycle where both are 1, and rd_en with ts_valid=0 is ignored.

  logic [31:0] timer_q, timer_d;
  logic [31:0] mem_q [4];
  logic [31:0] mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        ovf_q, ovf_d;

  logic        det_ok;
  logic        full;
  logic        pop;
  logic        push;

`ifdef DETECT_TIMESTAMP_HOLDOFF_EN
  logic [31:0] ho_q, ho_d;

  // Any accepted detect (stored or dropped) restarts the dead-time.
  always_comb begin
    ho_d = ho_q;
    if (ts_clear) begin
      ho_d = '0;
    end else if (det_ok) begin
      ho_d = holdoff;
    end else if (ho_q != 32'd0) begin
      ho_d = ho_q - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ho_q <= '0;
    end else begin
      ho_q <= ho_d;
    end
  end

  assign det_ok = detect && !ts_clear && (ho_q == 32'd0);
`else
  assign det_ok = detect && !ts_clear;
`endif

  assign full = (count_q == 3'd4);
  assign pop  = rd_en && !ts_clear && (count_q != 3'd0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push = det_ok && (!full || pop);

  always_comb begin
    timer_d  = timer_q + 32'd1;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (ts_clear) begin
      timer_d  = CLEAR_VALUE + 32'd1;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = timer_q;
        wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 2'd1;
      end
      count_d = count_q + {2'b00, push} - {2'b00, pop};
      if (det_ok && full && !pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      timer_q  <= timer_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign ts_valid = (count_q != 3'd0);
  assign ts_count = count_q;
  assign ts_data  = ts_valid ? mem_q[rd_ptr_q] : 32'd0;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_detect_timestamp.sv
// Directed bench for detect_timestamp: a vector table plus hand-written multi-cycle sequences.
// A second instance with a near-wrap clear value exercises the timer wrap.
module tb_detect_timestamp;

  logic        clk = 1'b0;
  logic        rst;
  logic        detect;
  logic        ts_clear;
  logic        rd_en;
  logic [31:0] holdoff;
  logic [31:0] ts_data, w_ts_data;
  logic        ts_valid, w_ts_valid;
  logic [2:0]  ts_count, w_ts_count;
  logic        overflow, w_overflow;

  int checks   = 0;
  int failures = 0;
  logic [31:0] tb_timer = 32'd0;

  always #5 clk = ~clk;

  detect_timestamp dut (
    .clk(clk), .rst(rst), .detect(detect), .ts_clear(ts_clear), .rd_en(rd_en),
`ifdef DETECT_TIMESTAMP_HOLDOFF_EN
    .holdoff(holdoff),
`endif
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_count(ts_count), .overflow(overflow)
  );

  detect_timestamp #(.CLEAR_VALUE(32'hFFFF_FFFD)) dut_wrap (
    .clk(clk), .rst(rst), .detect(detect), .ts_clear(ts_clear), .rd_en(rd_en),
`ifdef DETECT_TIMESTAMP_HOLDOFF_EN
    .holdoff(holdoff),
`endif
    .ts_data(w_ts_data), .ts_valid(w_ts_valid), .ts_count(w_ts_count), .overflow(w_overflow)
  );

  typedef struct {
    logic        det;
    logic        rd;
    logic        clr;
    logic        exp_valid;
    logic [2:0]  exp_count;
    logic [31:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: track the timer value the next cycle should show, then settle 1 time unit.
  task automatic tick();
    @(posedge clk);
    if (!rst) tb_timer = 32'd0;
    else if (ts_clear) tb_timer = 32'd1;
    else tb_timer = tb_timer + 32'd1;
    #1;
  endtask

  task automatic wait_timer(input logic [31:0] n);
    for (int k = 0; k < 300 && tb_timer != n; k++) tick();
    chk("wait_timer", tb_timer, n);
  endtask

  task automatic do_clear();
    ts_clear = 1'b1;
    tick();
    ts_clear = 1'b0;
  endtask

  task automatic det_at(input logic [31:0] n);
    wait_timer(n);
    detect = 1'b1;
    tick();
    detect = 1'b0;
  endtask

  task automatic rd_one(input string name, input logic [31:0] exp);
    chk({name, "_valid"}, {31'd0, ts_valid}, 32'd1);
    chk({name, "_data"}, ts_data, exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    // det rd clr | valid count data ovf ; vector i runs while the timer reads i+1
    vecs[0]  = '{0, 0, 0, 0, 3'd0, 32'd0,  0};
    vecs[1]  = '{1, 0, 0, 1, 3'd1, 32'd2,  0};
    vecs[2]  = '{0, 1, 0, 0, 3'd0, 32'd0,  0};
    vecs[3]  = '{0, 1, 0, 0, 3'd0, 32'd0,  0};
    vecs[4]  = '{1, 0, 0, 1, 3'd1, 32'd5,  0};
    vecs[5]  = '{1, 0, 0, 1, 3'd2, 32'd5,  0};
    vecs[6]  = '{1, 1, 0, 1, 3'd2, 32'd6,  0};
    vecs[7]  = '{1, 0, 0, 1, 3'd3, 32'd6,  0};
    vecs[8]  = '{1, 0, 0, 1, 3'd4, 32'd6,  0};
    vecs[9]  = '{1, 0, 0, 1, 3'd4, 32'd6,  1};
    vecs[10] = '{0, 1, 0, 1, 3'd3, 32'd7,  1};
    vecs[11] = '{0, 1, 0, 1, 3'd2, 32'd8,  1};
    vecs[12] = '{1, 0, 0, 1, 3'd3, 32'd8,  1};
    vecs[13] = '{0, 1, 0, 1, 3'd2, 32'd9,  1};
    vecs[14] = '{0, 1, 0, 1, 3'd1, 32'd13, 1};
    vecs[15] = '{0, 1, 0, 0, 3'd0, 32'd0,  1};
    vecs[16] = '{0, 0, 1, 0, 3'd0, 32'd0,  0};

    rst = 1'b0; detect = 1'b0; ts_clear = 1'b0; rd_en = 1'b0; holdoff = 32'd0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, ts_valid}, 32'd0);
    chk("rst_count", {29'd0, ts_count}, 32'd0);
    chk("rst_data", ts_data, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_wrap_valid", {31'd0, w_ts_valid}, 32'd0);
    rst = 1'b1;

    // Single entry round trip after reset release.
    det_at(32'd10);
    chk("s1_valid", {31'd0, ts_valid}, 32'd1);
    chk("s1_data", ts_data, 32'd10);
    chk("s1_count", {29'd0, ts_count}, 32'd1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("s1_empty_valid", {31'd0, ts_valid}, 32'd0);
    chk("s1_empty_data", ts_data, 32'd0);

    // Five detects, no reads: fifth is dropped and overflow sticks.
    do_clear();
    det_at(32'd20); det_at(32'd30); det_at(32'd40); det_at(32'd50);
    chk("s2_full_count", {29'd0, ts_count}, 32'd4);
    chk("s2_full_ovf", {31'd0, overflow}, 32'd0);
    det_at(32'd60);
    chk("s2_drop_count", {29'd0, ts_count}, 32'd4);
    chk("s2_drop_ovf", {31'd0, overflow}, 32'd1);
    rd_one("s2_rd0", 32'd20); rd_one("s2_rd1", 32'd30);
    rd_one("s2_rd2", 32'd40); rd_one("s2_rd3", 32'd50);
    chk("s2_empty", {31'd0, ts_valid}, 32'd0);
    chk("s2_sticky_ovf", {31'd0, overflow}, 32'd1);

    // Full FIFO with detect and read together accepts both.
    do_clear();
    chk("s3_clr_ovf", {31'd0, overflow}, 32'd0);
    det_at(32'd70); det_at(32'd80); det_at(32'd90); det_at(32'd95);
    wait_timer(32'd100);
    detect = 1'b1; rd_en = 1'b1;
    tick();
    detect = 1'b0; rd_en = 1'b0;
    chk("s3_count", {29'd0, ts_count}, 32'd4);
    chk("s3_ovf", {31'd0, overflow}, 32'd0);
    rd_one("s3_rd0", 32'd80); rd_one("s3_rd1", 32'd90);
    rd_one("s3_rd2", 32'd95); rd_one("s3_rd3", 32'd100);

    // Vector table, aligned so the first vector sees timer=1.
    do_clear();
    for (int i = 0; i < 17; i++) begin
      detect = vecs[i].det; rd_en = vecs[i].rd; ts_clear = vecs[i].clr;
      tick();
      detect = 1'b0; rd_en = 1'b0; ts_clear = 1'b0;
      chk($sformatf("v%0d_valid", i), {31'd0, ts_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("v%0d_count", i), {29'd0, ts_count}, {29'd0, vecs[i].exp_count});
      chk($sformatf("v%0d_data", i), ts_data, vecs[i].exp_data);
      chk($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
    end

    // Three entries plus overflow, then clear together with detect.
    do_clear();
    det_at(32'd2); det_at(32'd3); det_at(32'd4); det_at(32'd5); det_at(32'd6);
    rd_one("s4_rd0", 32'd2);
    chk("s4_pre_count", {29'd0, ts_count}, 32'd3);
    chk("s4_pre_ovf", {31'd0, overflow}, 32'd1);
    ts_clear = 1'b1; detect = 1'b1;
    tick();
    ts_clear = 1'b0; detect = 1'b0;
    chk("s4_clr_count", {29'd0, ts_count}, 32'd0);
    chk("s4_clr_ovf", {31'd0, overflow}, 32'd0);
    chk("s4_clr_valid", {31'd0, ts_valid}, 32'd0);
    detect = 1'b1; tick(); detect = 1'b0;
    chk("s4_timer_one", ts_data, 32'd1);
    detect = 1'b1; tick(); detect = 1'b0;
    chk("s4_two_count", {29'd0, ts_count}, 32'd2);
    // Asynchronous reset in the middle of a read cycle.
    rd_en = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("s4_arst_valid", {31'd0, ts_valid}, 32'd0);
    chk("s4_arst_count", {29'd0, ts_count}, 32'd0);
    chk("s4_arst_data", ts_data, 32'd0);
    chk("s4_arst_ovf", {31'd0, overflow}, 32'd0);
    tick();
    rd_en = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    chk("s4_no_stale_valid", {31'd0, ts_valid}, 32'd0);
    chk("s4_no_stale_data", ts_data, 32'd0);

`ifdef DETECT_TIMESTAMP_HOLDOFF_EN
    // Dead-time of 5 cycles after each detect.
    holdoff = 32'd5;
    do_clear();
    det_at(32'd10); det_at(32'd13); det_at(32'd15); det_at(32'd16);
    chk("s6_count", {29'd0, ts_count}, 32'd2);
    chk("s6_ovf", {31'd0, overflow}, 32'd0);
    rd_one("s6_rd0", 32'd10); rd_one("s6_rd1", 32'd16);
    holdoff = 32'd0;
`endif

    // Timer wrap on the near-wrap instance: it reads 0xFFFFFFFE right after the clear.
    do_clear();
    tick();
    detect = 1'b1;
    tick();
    tick();
    detect = 1'b0;
    chk("s5_wrap_count", {29'd0, w_ts_count}, 32'd2);
    chk("s5_wrap_data0", w_ts_data, 32'hFFFF_FFFF);
    chk("s5_main_data0", ts_data, 32'd2);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("s5_wrap_data1", w_ts_data, 32'h0000_0000);
    chk("s5_wrap_valid1", {31'd0, w_ts_valid}, 32'd1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("s5_wrap_empty", {31'd0, w_ts_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/detect_timestamp.md
DETECT_TIMESTAMP -- requirements
Module: detect_timestamp

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state is updated on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-003 SHALL have port detect, input, 1 bit: single-cycle detection pulse from the threshold stage.
REQ-004 SHALL have port ts_clear, input, 1 bit: synchronous clear of timer, FIFO and overflow.
REQ-005 SHALL have port rd_en, input, 1 bit: pops the head entry when ts_valid=1.
REQ-006 SHALL have port holdoff, input, 32 bits: dead-time in cycles; present only with the Configuration macro.
REQ-007 SHALL have port ts_data, output, 32 bits: timestamp at the FIFO head, first-word-fall-through.
REQ-008 SHALL have port ts_valid, output, 1 bit: FIFO not empty.
REQ-009 SHALL have port ts_count, output, 3 bits: number of stored entries, 0..4.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, a detect was dropped.

Function
REQ-011 SHALL run a free-running 32-bit timer that increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
REQ-012 SHALL, on a cycle with detect=1, write the timer value of that same cycle into a 4-entry FIFO; the entry becomes visible on ts_data/ts_valid one cycle later.
REQ-013 SHALL present the oldest entry on ts_data whenever ts_valid=1; ts_data SHALL be 0 when the FIFO is empty.
REQ-014 SHALL, on rd_en=1 with ts_valid=1, remove the head entry; the next entry, if any, appears the following cycle.
REQ-015 SHALL ignore rd_en=1 when the FIFO is empty; no pointer or count change occurs.
REQ-016 SHALL, when the FIFO is full (ts_count=4) and detect=1 with rd_en=0, drop the timestamp and set overflow=1 on the next cycle.
REQ-017 SHALL, when the FIFO is full and detect=1 with rd_en=1 in the same cycle, accept both: ts_count stays 4 and overflow is unchanged.
REQ-018 SHALL, on simultaneous detect and rd_en at any non-full level, keep ts_count unchanged.
REQ-019 SHALL keep overflow sticky until ts_clear or reset.
REQ-020 SHALL, on ts_clear=1: set the timer to 0, empty the FIFO, clear overflow and ignore detect and rd_en in that cycle; the timer reads 1 on the following cycle.
REQ-021 SHALL use circular 2-bit read and write pointers plus a 3-bit count; pointer wrap from 3 to 0 shall not corrupt the data.

Reset
REQ-022 SHALL, while rst=0, asynchronously force the following: timer=0, FIFO pointers=0, ts_count=0, ts_valid=0, ts_data=0, overflow=0, holdoff counter=0.
REQ-023 SHALL resume operation on the first rising edge after rst deasserts; the timer reads 0 in that cycle.
REQ-024 SHALL discard FIFO contents when reset is asserted mid-operation; no stale entry reappears.

Configuration
REQ-025 SHALL compile the holdoff feature only when macro DETECT_TIMESTAMP_HOLDOFF_EN is defined.
REQ-026 SHALL, with the macro defined, behave as follows after a detect at cycle T (whether stored or dropped): ignore detects in cycles T+1..T+holdoff, without affecting the FIFO or overflow; holdoff=0 disables the dead-time; ts_clear and reset clear the dead-time.
REQ-027 SHALL, without the macro, omit the holdoff port and counter; every detect is processed per REQ-012..REQ-018.

Verification
REQ-028 SHALL cover: release reset, detect at timer=10 -> ts_valid=1 next cycle, ts_data=10, ts_count=1; rd_en -> ts_valid=0, ts_data=0.
REQ-029 SHALL cover: 5 detects at timer 20,30,40,50,60 with no reads -> ts_count=4, overflow=1 after the 5th; reads return 20,30,40,50.
REQ-030 SHALL cover: FIFO full, detect and rd_en in the same cycle at timer=100 -> ts_count=4, overflow=0, last entry read = 100.
REQ-031 SHALL cover: timer preset near wrap via ts_clear at a known cycle, detect when the timer reads 0xFFFFFFFF and 1 cycle later -> entries 0xFFFFFFFF then 0x00000000.
REQ-032 SHALL cover: 3 stored entries and overflow=1, then ts_clear together with detect -> ts_count=0, overflow=0, nothing stored, timer=1 next cycle; rst=0 asserted mid-read -> all outputs 0 immediately.
REQ-033 SHALL cover, with DETECT_TIMESTAMP_HOLDOFF_EN defined and holdoff=5: detects at timer 10,13,15,16 -> stored 10 and 16 only, overflow=0.
